// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and default geometry for the convolution
// sequencer (conv_seq_ctrl) and its multiply-accumulate datapath (conv_mac).
package conv_pkg;

    localparam int NX_DEF = 8;   // input vector length
    localparam int NF_DEF = 4;   // filter length
    localparam int DW_DEF = 8;   // signed sample / coefficient width
    localparam int YW_DEF = 18;  // signed result width

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate. The full 2*DW-bit product is
// sign-extended to YW bits before accumulation; clear has priority over enable.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 enable,
    input  logic signed [DW-1:0] op_a,
    input  logic signed [DW-1:0] op_b,
    output logic signed [YW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [YW-1:0]   prod_ext;

    assign prod     = op_a * op_b;
    assign prod_ext = {{(YW-2*DW){prod[2*DW-1]}}, prod};

    // accumulator register: synchronous clear, otherwise add one product per enabled cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: loads an NX-sample vector and an NF-tap filter into external
// single-port memories, then streams out y[j] = sum_k x[j+k]*f[k] for
// j = 0..NX-NF. Optional macro CONV_SEQ_RELU_EN clamps negative results to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_LOAD    | accept x / f beats independently, write them to memory
// ST_COMPUTE | NF reads (x[j+k], f[k]) then one trailing accumulate cycle
// ST_OUTPUT  | present y[j] until m_ready_y, then next j or back to load
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int NX = NX_DEF,
    parameter int NF = NF_DEF,
    parameter int DW = DW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         s_data_x,
    input  logic                  s_valid_x,
    output logic                  s_ready_x,
    input  logic [DW-1:0]         s_data_f,
    input  logic                  s_valid_f,
    output logic                  s_ready_f,
    output logic [$clog2(NX)-1:0] x_addr,
    output logic                  x_wr_en,
    output logic [DW-1:0]         x_wdata,
    input  logic [DW-1:0]         x_rdata,
    output logic [$clog2(NF)-1:0] f_addr,
    output logic                  f_wr_en,
    output logic [DW-1:0]         f_wdata,
    input  logic [DW-1:0]         f_rdata,
    output logic [YW-1:0]         m_data_y,
    output logic                  m_valid_y,
    input  logic                  m_ready_y
);

    localparam int XAW = $clog2(NX);
    localparam int FAW = $clog2(NF);
    localparam int XCW = $clog2(NX + 1);
    localparam int FCW = $clog2(NF + 1);
    localparam int KW  = $clog2(NF + 1);

    localparam logic [XCW-1:0] X_FULL = XCW'(NX);
    localparam logic [FCW-1:0] F_FULL = FCW'(NF);
    localparam logic [KW-1:0]  K_LAST = KW'(NF);
    localparam logic [XAW-1:0] J_LAST = XAW'(NX - NF);

    conv_state_t state, state_nxt;

    logic [XCW-1:0]       x_cnt;
    logic [FCW-1:0]       f_cnt;
    logic [XAW-1:0]       j;
    logic [KW-1:0]        k;
    logic                 x_acc, f_acc, out_hs;
    logic                 mac_clr, mac_en;
    logic signed [YW-1:0] acc;
    logic [YW-1:0]        y_val;

    // state register, load counters, output index and read phase
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
            x_cnt <= '0;
            f_cnt <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            if (out_hs && state_nxt == ST_LOAD) begin
                x_cnt <= '0;
                f_cnt <= '0;
            end else begin
                if (x_acc) x_cnt <= x_cnt + XCW'(1);
                if (f_acc) f_cnt <= f_cnt + FCW'(1);
            end
            if (out_hs) j <= (state_nxt == ST_LOAD) ? '0 : j + XAW'(1);
            k <= (state == ST_COMPUTE && k != K_LAST) ? k + KW'(1) : '0;
        end
    end

    // next state, stream handshakes and memory port drive; everything idle while in reset
    always_comb begin
        state_nxt = state;
        s_ready_x = 1'b0;
        s_ready_f = 1'b0;
        x_acc     = 1'b0;
        f_acc     = 1'b0;
        x_wr_en   = 1'b0;
        x_addr    = '0;
        x_wdata   = '0;
        f_wr_en   = 1'b0;
        f_addr    = '0;
        f_wdata   = '0;
        m_valid_y = 1'b0;
        out_hs    = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = reset;
        if (!reset) begin
            unique case (state)
                ST_LOAD: begin
                    s_ready_x = (x_cnt < X_FULL);
                    s_ready_f = (f_cnt < F_FULL);
                    x_acc     = s_valid_x & s_ready_x;
                    f_acc     = s_valid_f & s_ready_f;
                    x_wr_en   = x_acc;
                    x_addr    = x_cnt[XAW-1:0];
                    x_wdata   = s_data_x;
                    f_wr_en   = f_acc;
                    f_addr    = f_cnt[FAW-1:0];
                    f_wdata   = s_data_f;
                    if (x_cnt == X_FULL && f_cnt == F_FULL) begin
                        state_nxt = ST_COMPUTE;
                        mac_clr   = 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    // read data arrives one cycle after the address, so phase k
                    // accumulates the pair addressed in phase k-1
                    if (k != K_LAST) begin
                        x_addr = j + XAW'(k);
                        f_addr = FAW'(k);
                    end
                    mac_en = (k != '0);
                    if (k == K_LAST) state_nxt = ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    m_valid_y = 1'b1;
                    out_hs    = m_ready_y;
                    if (m_ready_y) begin
                        if (j < J_LAST) begin
                            state_nxt = ST_COMPUTE;
                            mac_clr   = 1'b1;
                        end else begin
                            state_nxt = ST_LOAD;
                        end
                    end
                end
                default: state_nxt = ST_LOAD;
            endcase
        end
    end

    // result presentation; the accumulator is frozen outside COMPUTE so y stays stable
    always_comb begin
`ifdef CONV_SEQ_RELU_EN
        y_val = acc[YW-1] ? '0 : acc;
`else
        y_val = acc;
`endif
        m_data_y = reset ? '0 : y_val;
    end

    conv_mac #(
        .DW (DW),
        .YW (YW)
    ) u_mac (
        .clk    (clk),
        .clear  (mac_clr),
        .enable (mac_en),
        .op_a   (x_rdata),
        .op_b   (f_rdata),
        .acc    (acc)
    );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: bench for conv_seq_ctrl with behavioural x/f memories,
// a queue of expected results and an output monitor.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

    localparam int NX  = 8;
    localparam int NF  = 4;
    localparam int DW  = 8;
    localparam int YW  = 18;
    localparam int NY  = NX - NF + 1;
    localparam int XAW = $clog2(NX);
    localparam int FAW = $clog2(NF);

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  s_data_x, s_data_f;
    logic           s_valid_x, s_valid_f, s_ready_x, s_ready_f;
    logic [XAW-1:0] x_addr;
    logic [FAW-1:0] f_addr;
    logic           x_wr_en, f_wr_en;
    logic [DW-1:0]  x_wdata, f_wdata, x_rdata, f_rdata;
    logic [YW-1:0]  m_data_y;
    logic           m_valid_y;
    logic           m_ready_y;

    conv_seq_ctrl #(.NX(NX), .NF(NF), .DW(DW), .YW(YW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data_x  (s_data_x),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .s_data_f  (s_data_f),
        .s_valid_f (s_valid_f),
        .s_ready_f (s_ready_f),
        .x_addr    (x_addr),
        .x_wr_en   (x_wr_en),
        .x_wdata   (x_wdata),
        .x_rdata   (x_rdata),
        .f_addr    (f_addr),
        .f_wr_en   (f_wr_en),
        .f_wdata   (f_wdata),
        .f_rdata   (f_rdata),
        .m_data_y  (m_data_y),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y)
    );

    always #5 clk = ~clk;

    // memories with one-cycle read latency
    logic [DW-1:0] xmem [NX];
    logic [DW-1:0] fmem [NF];
    always @(posedge clk) begin
        if (x_wr_en) xmem[x_addr] <= x_wdata;
        if (f_wr_en) fmem[f_addr] <= f_wdata;
        x_rdata <= xmem[x_addr];
        f_rdata <= fmem[f_addr];
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired, got timeout expected completion at %0t", name, $time);
    endfunction

    logic [DW-1:0] xv [NX];
    logic [DW-1:0] fv [NF];
    int exp_q[$];

    // y[j] = sum_k x[j+k]*f[k], optionally rectified
    function automatic int ref_y(input int j);
        int s;
        s = 0;
        for (int k = 0; k < NF; k++) s += int'($signed(xv[j+k])) * int'($signed(fv[k]));
`ifdef CONV_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // downstream ready: 0 = always, 1 = hold low 10 cycles per result, 2 = random
    int rdy_mode = 0;
    int stall_cnt = 0;
    initial begin
        m_ready_y = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready_y = 1'b1;
                1: begin
                    if (m_valid_y && !m_ready_y) stall_cnt++;
                    else stall_cnt = 0;
                    m_ready_y = (stall_cnt >= 10);
                end
                default: m_ready_y = 1'($urandom);
            endcase
        end
    end

    // monitor: load-side write checks, ready model, first-result latency, result scoreboard
    int  cyc = 0;
    int  tb_xcnt = 0, tb_fcnt = 0;
    int  n_out = 0, n_load_out = 0;
    int  full_cyc = 0;
    bit  first_pending = 1'b0;
    bit  holding = 1'b0;
    int  held = 0;
    always @(negedge clk) begin
        bit acc_now;
        cyc++;
        acc_now = 1'b0;
        if (reset) begin
            exp_q.delete();
            holding       = 1'b0;
            first_pending = 1'b0;
            tb_xcnt       = 0;
            tb_fcnt       = 0;
            n_load_out    = 0;
        end else begin
            chk("s_ready_x", int'(s_ready_x), int'(tb_xcnt < NX));
            chk("s_ready_f", int'(s_ready_f), int'(tb_fcnt < NF));
            if (s_valid_x && s_ready_x) begin
                chk("x_wr_en", int'(x_wr_en), 1);
                chk("x_addr", int'(x_addr), tb_xcnt);
                chk("x_wdata", int'(x_wdata), int'(s_data_x));
                tb_xcnt++;
                acc_now = 1'b1;
            end else begin
                chk("x_wr_idle", int'(x_wr_en), 0);
            end
            if (s_valid_f && s_ready_f) begin
                chk("f_wr_en", int'(f_wr_en), 1);
                chk("f_addr", int'(f_addr), tb_fcnt);
                chk("f_wdata", int'(f_wdata), int'(s_data_f));
                tb_fcnt++;
                acc_now = 1'b1;
            end else begin
                chk("f_wr_idle", int'(f_wr_en), 0);
            end
            if (acc_now && tb_xcnt == NX && tb_fcnt == NF) begin
                full_cyc      = cyc;
                first_pending = 1'b1;
            end
            if (m_valid_y) begin
                if (first_pending) begin
                    chk("first_out_latency", cyc - full_cyc, NF + 3);
                    first_pending = 1'b0;
                end
                if (holding) chk("y_stable", int'($signed(m_data_y)), held);
                if (m_ready_y) begin
                    if (exp_q.size() == 0) begin
                        timeout("y_extra_output");
                    end else begin
                        chk("y_data", int'($signed(m_data_y)), exp_q.pop_front());
                    end
                    n_out++;
                    n_load_out++;
                    if (n_load_out == NY) begin
                        tb_xcnt    = 0;
                        tb_fcnt    = 0;
                        n_load_out = 0;
                    end
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = int'($signed(m_data_y));
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic send_x(input int max_gap);
        for (int i = 0; i < NX; i++) begin
            int gap;
            int guard;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            s_valid_x = 1'b1;
            s_data_x  = xv[i];
            guard = 0;
            @(negedge clk);
            while (!s_ready_x && guard < 300) begin @(negedge clk); guard++; end
            @(posedge clk);
            #1;
            s_valid_x = 1'b0;
            if (guard >= 300) begin timeout("x_send"); return; end
        end
    endtask

    task automatic send_f(input int max_gap);
        for (int i = 0; i < NF; i++) begin
            int gap;
            int guard;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            s_valid_f = 1'b1;
            s_data_f  = fv[i];
            guard = 0;
            @(negedge clk);
            while (!s_ready_f && guard < 300) begin @(negedge clk); guard++; end
            @(posedge clk);
            #1;
            s_valid_f = 1'b0;
            if (guard >= 300) begin timeout("f_send"); return; end
        end
    endtask

    task automatic drain(input int base);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin @(posedge clk); #1; guard++; end
        if (guard >= 3000) timeout("drain");
        @(posedge clk);
        #1;
        chk("outputs_per_load", n_out - base, NY);
        @(negedge clk);
        chk("idle_valid", int'(m_valid_y), 0);
        chk("idle_ready_x", int'(s_ready_x), 1);
        chk("idle_ready_f", int'(s_ready_f), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int xgap, input int fgap, input bit f_first);
        int base;
        for (int j = 0; j < NY; j++) exp_q.push_back(ref_y(j));
        base = n_out;
        if (f_first) begin
            send_f(fgap);
            send_x(xgap);
        end else begin
            fork
                send_x(xgap);
                send_f(fgap);
            join
        end
        drain(base);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NX; i++) xv[i] = DW'($urandom);
        for (int i = 0; i < NF; i++) fv[i] = DW'($urandom);
    endtask

    initial begin
        int base;
        int guard;
        reset     = 1'b1;
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        s_data_x  = '0;
        s_data_f  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_x", int'(s_ready_x), 0);
        chk("rst_ready_f", int'(s_ready_f), 0);
        chk("rst_valid_y", int'(m_valid_y), 0);
        chk("rst_x_wr_en", int'(x_wr_en), 0);
        chk("rst_f_wr_en", int'(f_wr_en), 0);
        chk("rst_data_y", int'(m_data_y), 0);
        chk("rst_x_addr", int'(x_addr), 0);
        chk("rst_f_addr", int'(f_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_x", int'(s_ready_x), 1);
        chk("post_rst_ready_f", int'(s_ready_f), 1);
        @(posedge clk);
        #1;

        // ramp x with unit filter: 10,14,18,22,26
        rdy_mode = 0;
        for (int i = 0; i < NX; i++) xv[i] = DW'(i + 1);
        for (int i = 0; i < NF; i++) fv[i] = DW'(1);
        run_load(0, 0, 1'b0);

        // most negative operands: 65536 each
        for (int i = 0; i < NX; i++) xv[i] = DW'(-128);
        for (int i = 0; i < NF; i++) fv[i] = DW'(-128);
        run_load(0, 0, 1'b0);

        // negating filter: -1..-5 (0 when rectified)
        for (int i = 0; i < NX; i++) xv[i] = DW'(i + 1);
        fv[0] = DW'(-1);
        for (int i = 1; i < NF; i++) fv[i] = DW'(0);
        run_load(1, 1, 1'b0);

        // slow consumer
        rdy_mode = 1;
        rand_data();
        run_load(2, 2, 1'b0);

        // filter fully first, then x with gaps
        rdy_mode = 0;
        rand_data();
        run_load(4, 0, 1'b1);

        // random interleaving and random backpressure
        rdy_mode = 2;
        repeat (3) begin
            rand_data();
            run_load(3, 3, 1'b0);
        end

        // reset while computing j=2
        rdy_mode = 0;
        rand_data();
        for (int j = 0; j < NY; j++) exp_q.push_back(ref_y(j));
        base = n_out;
        fork
            send_x(0);
            send_f(0);
        join
        guard = 0;
        while (n_out < base + 2 && guard < 500) begin @(posedge clk); #1; guard++; end
        if (guard >= 500) timeout("reach_j2");
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid_y", int'(m_valid_y), 0);
        chk("mid_rst_ready_x", int'(s_ready_x), 0);
        chk("mid_rst_ready_f", int'(s_ready_f), 0);
        chk("mid_rst_data_y", int'(m_data_y), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_ready_x", int'(s_ready_x), 1);
        chk("after_rst_ready_f", int'(s_ready_f), 1);
        chk("after_rst_valid_y", int'(m_valid_y), 0);
        @(posedge clk);
        #1;

        rand_data();
        run_load(1, 1, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
